// File: rtl/reg_bus_pkg.sv
// Shared definitions for the register-bus master/arbiter.
package reg_bus_pkg;

   localparam int ADDR_W = 8;
   localparam int DATA_W = 8;

   // IDLE: arbitrate, ACCESS: bus cycle, TURN: bus released and response issued
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      TURN   = 2'd2
   } state_t;

   localparam logic OP_RD = 1'b0;
   localparam logic OP_WR = 1'b1;

   // Index width for n requesters; a single requester still needs one bit
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping.
module rr_arbiter #(
   parameter int NREQ  = 2,
   parameter int IDX_W = 1
) (
   input  logic [NREQ-1:0]  req,
   input  logic [IDX_W-1:0] ptr,
   output logic [NREQ-1:0]  grant,
   output logic [IDX_W-1:0] idx,
   output logic             any
);

   // Scan NREQ positions starting at ptr; the first valid one wins
   always_comb begin
      int cand;
      grant = '0;
      idx   = '0;
      any   = 1'b0;
      cand  = 0;
      for (int off = 0; off < NREQ; off++) begin
         cand = (int'(ptr) + off) % NREQ;
         if (!any && req[cand]) begin
            any         = 1'b1;
            grant[cand] = 1'b1;
            idx         = IDX_W'(cand);
         end
      end
   end

endmodule

// File: rtl/reg_bus_master_arb.sv
// Round-robin arbiter and single-access sequencer for the shared 8-bit register bus.
// One request is accepted in IDLE, driven on the bus in ACCESS, and completed in TURN
// while the bus is released, so the data pin is never driven during a read.
module reg_bus_master_arb
   import reg_bus_pkg::*;
#(
   parameter int NREQ    = 2,
   parameter int RD_WAIT = 1
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [NREQ-1:0]        req_valid,
   output logic [NREQ-1:0]        req_ready,
   input  logic [NREQ-1:0]        req_wr,
   input  logic [NREQ*ADDR_W-1:0] req_addr,
   input  logic [NREQ*DATA_W-1:0] req_wdata,
   output logic [NREQ-1:0]        rsp_valid,
   output logic [DATA_W-1:0]      rsp_rdata,
   output logic                   bus_sel,
   output logic                   bus_wr,
   output logic [ADDR_W-1:0]      bus_addr,
   output logic [DATA_W-1:0]      bus_dout,
   output logic                   bus_oe,
   input  logic [DATA_W-1:0]      bus_din,
   output logic                   busy
);

   localparam int IDX_W = idx_w(NREQ);

   state_t             state;
   logic [IDX_W-1:0]   rr_ptr;
   logic [IDX_W-1:0]   win_idx;
   logic [IDX_W-1:0]   id_q;
   logic [NREQ-1:0]    grant;
   logic               any_req;
   logic               wr_q;
   logic [2:0]         wait_cnt;
   logic               sel_wr;
   logic [ADDR_W-1:0]  sel_addr;
   logic [DATA_W-1:0]  sel_wdata;

   rr_arbiter #(.NREQ(NREQ), .IDX_W(IDX_W)) u_arb (
      .req   (req_valid),
      .ptr   (rr_ptr),
      .grant (grant),
      .idx   (win_idx),
      .any   (any_req)
   );

   // Accept only in IDLE and never while reset is held, so every output is 0 in reset
   assign req_ready = (reset && state == IDLE) ? grant : '0;

   assign sel_wr    = req_wr[win_idx];
   assign sel_addr  = req_addr[int'(win_idx)*ADDR_W +: ADDR_W];
   assign sel_wdata = req_wdata[int'(win_idx)*DATA_W +: DATA_W];

   // Access sequencer: the bus_* registers double as the captured request fields
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         rr_ptr    <= '0;
         id_q      <= '0;
         wr_q      <= OP_RD;
         wait_cnt  <= '0;
         bus_sel   <= 1'b0;
         bus_wr    <= 1'b0;
         bus_addr  <= '0;
         bus_dout  <= '0;
         bus_oe    <= 1'b0;
         rsp_valid <= '0;
         rsp_rdata <= '0;
         busy      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               rsp_valid <= '0;
               rsp_rdata <= '0;
               if (any_req) begin
                  id_q     <= win_idx;
                  wr_q     <= sel_wr;
                  rr_ptr   <= (int'(win_idx) == NREQ-1) ? '0 : win_idx + 1'b1;
                  wait_cnt <= '0;
                  bus_sel  <= 1'b1;
                  bus_wr   <= sel_wr;
                  bus_addr <= sel_addr;
                  bus_dout <= sel_wr ? sel_wdata : '0;
                  bus_oe   <= sel_wr;
                  busy     <= 1'b1;
                  state    <= ACCESS;
               end
            end
            ACCESS: begin
               // Writes commit in one cycle; reads hold sel RD_WAIT extra cycles
               if (wr_q == OP_WR || wait_cnt == 3'(RD_WAIT)) begin
                  bus_sel   <= 1'b0;
                  bus_wr    <= 1'b0;
                  bus_oe    <= 1'b0;
                  bus_addr  <= '0;
                  bus_dout  <= '0;
                  rsp_valid <= NREQ'(1) << id_q;
                  rsp_rdata <= (wr_q == OP_WR) ? '0 : bus_din;
                  state     <= TURN;
               end else begin
                  wait_cnt <= wait_cnt + 3'd1;
               end
            end
            TURN: begin
               rsp_valid <= '0;
               rsp_rdata <= '0;
               busy      <= 1'b0;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_reg_bus_master_arb.sv
// Bench for reg_bus_master_arb: directed timing checks plus randomized traffic from two
// agents, scored against a memory model and a round-robin grant model.
module tb_reg_bus_master_arb;

   localparam int NREQ    = 2;
   localparam int RD_WAIT = 1;

   logic                clk = 1'b0;
   logic                reset = 1'b0;
   logic [NREQ-1:0]     req_valid, req_ready, req_wr, rsp_valid;
   logic [NREQ*8-1:0]   req_addr, req_wdata;
   logic [7:0]          rsp_rdata, bus_addr, bus_dout, bus_din;
   logic                bus_sel, bus_wr, bus_oe, busy;

   logic                a_valid [NREQ];
   logic                a_wr    [NREQ];
   logic [7:0]          a_addr  [NREQ];
   logic [7:0]          a_wdata [NREQ];

   typedef struct {
      logic [NREQ-1:0] id;
      logic [7:0]      data;
   } exp_t;

   exp_t       sb_q[$];
   int         grant_log[$];
   logic [7:0] mdl_mem [256];
   logic [7:0] tgt_mem [256];
   int         mptr = 0;
   int         sel_cnt = 0;
   int         cyc = 0;
   int         n_cmp = 0;
   int         n_bad = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < NREQ; g++) begin : g_pack
      assign req_valid[g]          = a_valid[g];
      assign req_wr[g]             = a_wr[g];
      assign req_addr[8*g +: 8]    = a_addr[g];
      assign req_wdata[8*g +: 8]   = a_wdata[g];
   end

   reg_bus_master_arb #(.NREQ(NREQ), .RD_WAIT(RD_WAIT)) dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_wr    (req_wr),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .rsp_valid (rsp_valid),
      .rsp_rdata (rsp_rdata),
      .bus_sel   (bus_sel),
      .bus_wr    (bus_wr),
      .bus_addr  (bus_addr),
      .bus_dout  (bus_dout),
      .bus_oe    (bus_oe),
      .bus_din   (bus_din),
      .busy      (busy)
   );

   // Register-file target: data only valid once sel has been held RD_WAIT cycles
   assign bus_din = (bus_sel && !bus_wr && sel_cnt >= RD_WAIT) ? tgt_mem[bus_addr] : 8'hEE;

   always @(posedge clk) begin
      cyc     <= cyc + 1;
      sel_cnt <= bus_sel ? sel_cnt + 1 : 0;
      if (bus_sel && bus_wr && bus_oe) tgt_mem[bus_addr] <= bus_dout;
   end

   function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] expv);
      n_cmp++;
      if (act !== expv) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, expv, cyc);
      end
   endfunction

   // Drive one request from agent a until accepted; returns the cycle after the accept edge
   task automatic issue(input int a, input logic wr, input logic [7:0] addr,
                        input logic [7:0] data, output int acc_cyc);
      bit   done;
      exp_t e;
      done = 0;
      @(posedge clk); #1;
      a_wr[a] = wr; a_addr[a] = addr; a_wdata[a] = data; a_valid[a] = 1'b1;
      for (int k = 0; k < 300 && !done; k++) begin
         @(negedge clk);
         if (req_ready[a]) begin
            e.id   = NREQ'(1) << a;
            e.data = wr ? 8'h00 : mdl_mem[addr];
            if (wr) mdl_mem[addr] = data;
            sb_q.push_back(e);
            done = 1;
         end
      end
      @(posedge clk); #1;
      a_valid[a] = 1'b0;
      acc_cyc = cyc;
      if (!done) begin
         n_cmp++; n_bad++;
         $display("FAIL issue_timeout: agent %0d got no ready expected ready", a);
      end
   endtask

   // Grant model: in IDLE the first valid agent at or after the pointer wins
   always @(negedge clk) begin : arb_mon
      logic [NREQ-1:0] expg;
      int w, c;
      if (!reset) begin
         mptr = 0;
      end else begin
         expg = '0;
         w = -1;
         if (!busy) begin
            for (int k = 0; k < NREQ; k++) begin
               c = (mptr + k) % NREQ;
               if (w < 0 && req_valid[c]) begin
                  w = c;
                  expg[c] = 1'b1;
               end
            end
         end
         check("req_ready", req_ready, expg);
         if (w >= 0) begin
            mptr = (w + 1) % NREQ;
            grant_log.push_back(w);
         end
         if (bus_oe) check("oe_only_write_access", {bus_sel, bus_wr}, 2'b11);
      end
   end

   // Response monitor: every completion must match the oldest outstanding expectation
   always @(negedge clk) begin : rsp_mon
      exp_t e;
      if (reset && rsp_valid != '0) begin
         if (sb_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL rsp_unexpected: got rsp_valid %0h expected none", rsp_valid);
         end else begin
            e = sb_q.pop_front();
            check("rsp_id", rsp_valid, e.id);
            check("rsp_rdata", rsp_rdata, e.data);
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish expected finish");
      $fatal(1);
   end

   initial begin
      int t;
      int tb2b [3];
      for (int i = 0; i < 256; i++) begin
         tgt_mem[i] = 8'(i * 7 + 3);
         mdl_mem[i] = 8'(i * 7 + 3);
      end
      for (int a = 0; a < NREQ; a++) begin
         a_valid[a] = 1'b0; a_wr[a] = 1'b0; a_addr[a] = '0; a_wdata[a] = '0;
      end

      // Reset held 5 cycles with a request pending: nothing may be accepted
      a_valid[0] = 1'b1;
      repeat (5) @(posedge clk);
      @(negedge clk);
      check("rst_sel", bus_sel, 1'b0);
      check("rst_oe", bus_oe, 1'b0);
      check("rst_ready", req_ready, '0);
      check("rst_rsp", rsp_valid, '0);
      check("rst_busy", busy, 1'b0);
      a_valid[0] = 1'b0;
      reset = 1'b1;

      // Single write from agent 0
      issue(0, 1'b1, 8'h23, 8'hA5, t);
      @(negedge clk);
      check("wr_sel", bus_sel, 1'b1);
      check("wr_wr", bus_wr, 1'b1);
      check("wr_addr", bus_addr, 8'h23);
      check("wr_dout", bus_dout, 8'hA5);
      check("wr_oe", bus_oe, 1'b1);
      @(negedge clk);
      check("wr_turn_sel", bus_sel, 1'b0);
      check("wr_turn_rsp", rsp_valid, 2'b01);

      // Read back from agent 1: sel held 1+RD_WAIT cycles, pin never driven
      issue(1, 1'b0, 8'h23, 8'h00, t);
      for (int k = 0; k <= RD_WAIT; k++) begin
         @(negedge clk);
         check("rd_sel", bus_sel, 1'b1);
         check("rd_wr", bus_wr, 1'b0);
         check("rd_oe", bus_oe, 1'b0);
         check("rd_addr", bus_addr, 8'h23);
      end
      @(negedge clk);
      check("rd_turn_sel", bus_sel, 1'b0);
      check("rd_turn_rsp", rsp_valid, 2'b10);
      check("rd_turn_data", rsp_rdata, 8'hA5);

      // Fairness: both agents continuously requesting alternate grants
      grant_log.delete();
      fork
         begin int tt; for (int n = 0; n < 4; n++) issue(0, 1'b1, 8'($urandom_range(0, 15)), 8'($urandom), tt); end
         begin int tt; for (int n = 0; n < 4; n++) issue(1, 1'b1, 8'($urandom_range(0, 15)), 8'($urandom), tt); end
      join
      check("fair_count", grant_log.size(), 8);
      for (int k = 0; k < grant_log.size(); k++) check("fair_order", grant_log[k], k % 2);

      // Back-to-back writes from one agent: one accept every 3 cycles
      for (int n = 0; n < 3; n++) issue(0, 1'b1, 8'(8'h30 + n), 8'($urandom), tb2b[n]);
      check("b2b_gap1", tb2b[1] - tb2b[0], 3);
      check("b2b_gap2", tb2b[2] - tb2b[1], 3);

      // Reset in the middle of a read: no response, pointer back to agent 0
      issue(1, 1'b0, 8'h40, 8'h00, t);
      #2;
      check("mid_sel_before", bus_sel, 1'b1);
      reset = 1'b0;
      sb_q.delete();
      #1;
      check("mid_sel_async", bus_sel, 1'b0);
      check("mid_oe_async", bus_oe, 1'b0);
      check("mid_busy_async", busy, 1'b0);
      repeat (3) @(negedge clk);
      reset = 1'b1;
      grant_log.delete();
      fork
         begin int tt; issue(1, 1'b0, 8'h23, 8'h00, tt); end
         begin int tt; issue(0, 1'b0, 8'h31, 8'h00, tt); end
      join
      check("post_rst_first", grant_log.size() > 0 ? grant_log[0] : -1, 0);

      // Randomized mixed traffic over a small address window to force read-after-write hits
      fork
         begin
            int tt;
            for (int n = 0; n < 30; n++) begin
               repeat ($urandom_range(0, 3)) @(posedge clk);
               issue(0, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 7)), 8'($urandom), tt);
            end
         end
         begin
            int tt;
            for (int n = 0; n < 30; n++) begin
               repeat ($urandom_range(0, 3)) @(posedge clk);
               issue(1, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 7)), 8'($urandom), tt);
            end
         end
      join

      // Drain outstanding responses
      for (int k = 0; k < 50 && sb_q.size() != 0; k++) @(negedge clk);
      check("drain_empty", sb_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
